vec_quad_map: RTL and testbench
===============================

Name: vec_quad_map

Overview:
- Quadrant handler for CORDIC vectoring mode. It is the counterpart of the rotation-mode quadrant pre-check.
- Front end: maps any input vector into the right half-plane (x >= 0) before it enters the vectoring CORDIC core.
- Back end: restores the full-range angle on the core's output.
- Quadrant codes are held in a FIFO between the two ends, so the block tolerates any core latency up to DEPTH in-flight samples.
- quad_out is emitted in sign-bit format, ready to drive the rotation-mode quad_in.

Parameters:
- DATA_WIDTH, 16, width of x/y/magnitude (signed two's complement).
- ANGLE_WIDTH, 16, width of angle. Signed; MSB weight = -pi, so 2^(ANGLE_WIDTH-2) = pi/2.
- CORDIC_STAGES, 16, width of micro-rotation direction vector.
- DEPTH, 32, quad FIFO depth. Must be a power of 2 and >= core latency in samples.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  x_in/y_in sample valid.
- in_ready  out  1  block can accept a sample; equals ~fifo_full.
- x_in  in  DATA_WIDTH  input vector x, signed.
- y_in  in  DATA_WIDTH  input vector y, signed.
- pre_valid  out  1  pre_x/pre_y valid to the CORDIC core.
- pre_x  out  DATA_WIDTH  mapped x (always >= 0).
- pre_y  out  DATA_WIDTH  mapped y.
- core_valid  in  1  CORDIC core result valid.
- core_mag  in  DATA_WIDTH  core magnitude output.
- core_angle  in  ANGLE_WIDTH  core angle, in (-pi/2, pi/2].
- core_micro_rot  in  CORDIC_STAGES  core micro-rotation directions.
- out_valid  out  1  corrected result valid.
- mag_out  out  DATA_WIDTH  magnitude, passed through.
- angle_out  out  ANGLE_WIDTH  full-range angle in [-pi, pi).
- micro_rot_out  out  CORDIC_STAGES  micro-rotation directions, passed through.
- quad_out  out  2  quadrant code {y_sign, x_sign}: 00 Q1, 01 Q2, 11 Q3, 10 Q4.
- ovf_err  out  1  sticky: push attempted while FIFO full.
- unf_err  out  1  sticky: core_valid seen while FIFO empty.

Behaviour:
- Reset is synchronous and active-high. When reset is high at a rising clk edge:
  - all outputs, FIFO pointers, count and both sticky flags are cleared to 0;
  - in_ready reads 1 on the cycle after reset.
  - Reset mid-operation discards all in-flight quad codes. Core results that arrive afterwards are handled under the unf_err rule below.
- Accept condition: acc = in_valid & in_ready.
- Front end is registered, latency 1: pre_valid <= acc.
- Front end mapping, computed on an accepted sample:
  - q = {y_in[MSB], x_in[MSB]}.
  - If x_in[MSB] = 1: pre_x = -x_in and pre_y = -y_in (two's complement).
  - Else: pre_x = x_in and pre_y = y_in.
  - Negating the most-negative value (-2^(DATA_WIDTH-1)) saturates to 2^(DATA_WIDTH-1)-1. This applies independently to x and y.
- pre_x and pre_y hold their last value when pre_valid = 0.
- x_in = 0 counts as x >= 0: no negation, so q[0] = 0.
- FIFO behaviour:
  - Push q on acc.
  - Pop on core_valid & ~fifo_empty.
  - Push and pop in the same cycle at full: not possible, because in_ready = 0 blocks the push. The pop proceeds.
  - Push and pop in the same cycle at empty: the push is stored and the pop is treated as empty (see the unf_err rule). Bypass is not required.
  - Pointers wrap modulo DEPTH. Count is tracked 0..DEPTH.
  - fifo_full = (count == DEPTH); fifo_empty = (count == 0).
- ovf_err is set if in_valid = 1 while full. The sample is dropped and no state changes.
- Back end is registered, latency 1: out_valid <= core_valid.
- Back end outputs: mag_out <= core_mag; micro_rot_out <= core_micro_rot; quad_out <= popped q.
- Angle correction:
  - If q[0] = 1 (Q2 or Q3): angle_out = {~core_angle[MSB], core_angle[ANGLE_WIDTH-2:0]}, i.e. +pi modulo 2pi.
  - Else: angle_out = core_angle.
- core_valid while FIFO empty:
  - out_valid still asserts;
  - q is taken as 00 and no correction is applied;
  - unf_err is set and no pointer moves.
- Output registers hold their values when out_valid = 0.
- Sticky flags clear only on reset.
- No backpressure on the back end: the core output is never stalled.

Test Plan:
- Reset, then check outputs -> all outputs 0, in_ready = 1, both error flags 0.
- Q2: x = -100, y = 100 -> next cycle pre_x = 100, pre_y = -100. Drive core_angle = 0xE000 -> angle_out = 0x6000, quad_out = 01.
- Q3 and Q1/Q4:
  - x = -100, y = -100, core_angle = 0x2000 -> angle_out = 0xA000, quad_out = 11.
  - x = 50, y = -50, core_angle = 0xE000 -> angle_out = 0xE000, quad_out = 10.
- Saturation: x = 0x8000, y = 0x8000 -> pre_x = 0x7FFF, pre_y = 0x7FFF, quad_out = 11.
- FIFO stress:
  - Push DEPTH samples with no core_valid -> in_ready = 0.
  - One extra in_valid -> ovf_err = 1, sample dropped.
  - Pop all DEPTH samples -> quad codes come out in order, then in_ready = 1.
  - Continuous push/pop across pointer wrap -> order is preserved.
- Underflow and reset:
  - core_valid with FIFO empty -> out_valid = 1, angle passed through, unf_err = 1.
  - Assert reset with 5 codes in flight -> FIFO empty, unf_err = 0. The next core_valid sets unf_err.

Source files
------------

// File: rtl/vec_quad_map.sv
// Quadrant handler for a CORDIC vectoring core: folds input vectors into the
// right half-plane and restores the full-range angle on the core's output.
module vec_quad_map #(
    parameter int DATA_WIDTH    = 16,
    parameter int ANGLE_WIDTH   = 16,
    parameter int CORDIC_STAGES = 16,
    parameter int DEPTH         = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    x_in,
    input  logic [DATA_WIDTH-1:0]    y_in,
    output logic                     pre_valid,
    output logic [DATA_WIDTH-1:0]    pre_x,
    output logic [DATA_WIDTH-1:0]    pre_y,
    input  logic                     core_valid,
    input  logic [DATA_WIDTH-1:0]    core_mag,
    input  logic [ANGLE_WIDTH-1:0]   core_angle,
    input  logic [CORDIC_STAGES-1:0] core_micro_rot,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    mag_out,
    output logic [ANGLE_WIDTH-1:0]   angle_out,
    output logic [CORDIC_STAGES-1:0] micro_rot_out,
    output logic [1:0]               quad_out,
    output logic                     ovf_err,
    output logic                     unf_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MOST_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    logic [1:0]    quad_mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_full, fifo_empty;
    logic          acc, pop;
    logic [1:0]    in_q, popped_q;
    logic [ANGLE_WIDTH-1:0] corrected_angle;

    // Two's-complement negate; the most-negative value has no positive twin.
    function automatic logic [DATA_WIDTH-1:0] sat_neg(input logic [DATA_WIDTH-1:0] v);
        if (v == MOST_NEG)
            return MOST_POS;
        return -v;
    endfunction

    assign fifo_full  = (count == CW'(DEPTH));
    assign fifo_empty = (count == '0);
    assign in_ready   = ~fifo_full;
    assign acc        = in_valid & in_ready;
    assign pop        = core_valid & ~fifo_empty;
    assign in_q       = {y_in[DATA_WIDTH-1], x_in[DATA_WIDTH-1]};
    assign popped_q   = pop ? quad_mem[rd_ptr] : 2'b00;

    // Left-half-plane samples were rotated by pi on the way in; add it back.
    assign corrected_angle = popped_q[0]
        ? {~core_angle[ANGLE_WIDTH-1], core_angle[ANGLE_WIDTH-2:0]}
        : core_angle;

    // NOTE: the quad storage has no reset; pointers and count alone define
    // which entries are live, so clearing the array buys nothing.
    always_ff @(posedge clk) begin
        if (acc)
            quad_mem[wr_ptr] <= in_q;
    end

    // NOTE: every register below uses non-blocking assignment so all of them
    // update together from values sampled before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            pre_valid     <= 1'b0;
            pre_x         <= '0;
            pre_y         <= '0;
            out_valid     <= 1'b0;
            mag_out       <= '0;
            angle_out     <= '0;
            micro_rot_out <= '0;
            quad_out      <= 2'b00;
            ovf_err       <= 1'b0;
            unf_err       <= 1'b0;
        end else begin
            pre_valid <= acc;
            if (acc) begin
                wr_ptr <= wr_ptr + PW'(1);
                if (x_in[DATA_WIDTH-1]) begin
                    pre_x <= sat_neg(x_in);
                    pre_y <= sat_neg(y_in);
                end else begin
                    pre_x <= x_in;
                    pre_y <= y_in;
                end
            end

            if (pop)
                rd_ptr <= rd_ptr + PW'(1);

            case ({acc, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            out_valid <= core_valid;
            if (core_valid) begin
                mag_out       <= core_mag;
                micro_rot_out <= core_micro_rot;
                angle_out     <= corrected_angle;
                quad_out      <= popped_q;
            end

            if (in_valid & fifo_full)
                ovf_err <= 1'b1;
            if (core_valid & fifo_empty)
                unf_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vec_quad_map.sv
// Directed bench for vec_quad_map: quadrant mapping, angle restore, FIFO
// ordering across wrap, overflow/underflow flags and mid-stream reset.
module tb_vec_quad_map;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int CS = 16;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] x_in, y_in;
    logic          pre_valid;
    logic [DW-1:0] pre_x, pre_y;
    logic          core_valid;
    logic [DW-1:0] core_mag;
    logic [AW-1:0] core_angle;
    logic [CS-1:0] core_micro_rot;
    logic          out_valid;
    logic [DW-1:0] mag_out;
    logic [AW-1:0] angle_out;
    logic [CS-1:0] micro_rot_out;
    logic [1:0]    quad_out;
    logic          ovf_err, unf_err;

    int checks = 0;
    int passed = 0;

    vec_quad_map #(
        .DATA_WIDTH(DW), .ANGLE_WIDTH(AW), .CORDIC_STAGES(CS), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .y_in(y_in),
        .pre_valid(pre_valid), .pre_x(pre_x), .pre_y(pre_y),
        .core_valid(core_valid), .core_mag(core_mag), .core_angle(core_angle),
        .core_micro_rot(core_micro_rot),
        .out_valid(out_valid), .mag_out(mag_out), .angle_out(angle_out),
        .micro_rot_out(micro_rot_out), .quad_out(quad_out),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 clk = ~clk;

    // Directed vectors: input, expected mapped vector, core angle, expected angle/quad.
    localparam logic [DW-1:0] TX  [6] = '{16'hFF9C, 16'hFF9C, 16'h0032, 16'h0000, 16'h8000, 16'h8000};
    localparam logic [DW-1:0] TY  [6] = '{16'h0064, 16'hFF9C, 16'hFFCE, 16'h0005, 16'h8000, 16'h0001};
    localparam logic [DW-1:0] EPX [6] = '{16'h0064, 16'h0064, 16'h0032, 16'h0000, 16'h7FFF, 16'h7FFF};
    localparam logic [DW-1:0] EPY [6] = '{16'hFF9C, 16'h0064, 16'hFFCE, 16'h0005, 16'h7FFF, 16'hFFFF};
    localparam logic [AW-1:0] TA  [6] = '{16'hE000, 16'h2000, 16'hE000, 16'h1000, 16'h1234, 16'hFFFF};
    localparam logic [AW-1:0] EA  [6] = '{16'h6000, 16'hA000, 16'hE000, 16'h1000, 16'h9234, 16'h7FFF};
    localparam logic [1:0]    EQ  [6] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b11, 2'b01};

    // Advance one clock and settle 1 ns past the edge before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] code_of(input int i);
        logic [7:0] b;
        b = 8'(i);
        return b[1:0] ^ b[3:2];
    endfunction

    task automatic drive_code(input logic [1:0] q);
        x_in = q[0] ? 16'(-300) : 16'd300;
        y_in = q[1] ? 16'(-7)   : 16'd7;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({pre_valid, out_valid, ovf_err, unf_err, quad_out} !== 6'b0)
            $display("FAIL reset_ctrl: got %b expected 000000", {pre_valid, out_valid, ovf_err, unf_err, quad_out});
        else passed++;
        checks++;
        if ({pre_x, pre_y, mag_out, angle_out, micro_rot_out} !== 80'h0)
            $display("FAIL reset_data: got %h expected 0", {pre_x, pre_y, mag_out, angle_out, micro_rot_out});
        else passed++;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        else passed++;
    endtask

    task automatic test_quadrants();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; x_in = TX[i]; y_in = TY[i];
            tick();
            in_valid = 1'b0;
            checks++;
            if ({pre_valid, pre_x, pre_y} !== {1'b1, EPX[i], EPY[i]})
                $display("FAIL map[%0d]: got v=%b x=%h y=%h expected v=1 x=%h y=%h", i, pre_valid, pre_x, pre_y, EPX[i], EPY[i]);
            else passed++;
            core_valid = 1'b1; core_angle = TA[i];
            core_mag = 16'h0100 + 16'(i); core_micro_rot = 16'hA5A0 + 16'(i);
            tick();
            core_valid = 1'b0;
            checks++;
            if ({out_valid, angle_out, quad_out} !== {1'b1, EA[i], EQ[i]})
                $display("FAIL angle[%0d]: got v=%b a=%h q=%b expected v=1 a=%h q=%b", i, out_valid, angle_out, quad_out, EA[i], EQ[i]);
            else passed++;
            checks++;
            if ({mag_out, micro_rot_out} !== {16'h0100 + 16'(i), 16'hA5A0 + 16'(i)})
                $display("FAIL passthru[%0d]: got mag=%h mr=%h", i, mag_out, micro_rot_out);
            else passed++;
            checks++;
            if ({pre_valid, pre_x, pre_y} !== {1'b0, EPX[i], EPY[i]})
                $display("FAIL pre_hold[%0d]: got v=%b x=%h y=%h expected v=0 x=%h y=%h", i, pre_valid, pre_x, pre_y, EPX[i], EPY[i]);
            else passed++;
        end
        tick();
        checks++;
        if ({out_valid, angle_out, quad_out} !== {1'b0, EA[5], EQ[5]})
            $display("FAIL out_hold: got v=%b a=%h q=%b expected v=0 a=%h q=%b", out_valid, angle_out, quad_out, EA[5], EQ[5]);
        else passed++;
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1; drive_code(code_of(i));
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if ({in_ready, ovf_err} !== 2'b00) $display("FAIL full: got rdy/ovf=%b expected 00", {in_ready, ovf_err});
        else passed++;
        in_valid = 1'b1; drive_code(2'b11);
        tick();
        in_valid = 1'b0;
        checks++;
        if ({ovf_err, pre_valid} !== 2'b10) $display("FAIL overflow: got ovf/pre_valid=%b expected 10", {ovf_err, pre_valid});
        else passed++;
        core_angle = 16'h0000;
        for (int i = 0; i < DEPTH; i++) begin
            core_valid = 1'b1;
            tick();
            checks++;
            if ({out_valid, quad_out} !== {1'b1, code_of(i)})
                $display("FAIL drain[%0d]: got v=%b q=%b expected v=1 q=%b", i, out_valid, quad_out, code_of(i));
            else passed++;
        end
        core_valid = 1'b0;
        tick();
        checks++;
        if ({in_ready, unf_err, ovf_err} !== 3'b101) $display("FAIL drained: got rdy/unf/ovf=%b expected 101", {in_ready, unf_err, ovf_err});
        else passed++;
    endtask

    task automatic test_wrap();
        logic [1:0] model [$];
        logic [1:0] exp_q;
        for (int c = 0; c < 70; c++) begin
            in_valid = (c < 50);
            core_valid = (c >= 20);
            exp_q = 2'b00;
            if (c < 50) begin
                drive_code(code_of(c + 5));
                model.push_back(code_of(c + 5));
            end
            if (c >= 20) exp_q = model.pop_front();
            tick();
            if (c >= 20) begin
                checks++;
                if ({out_valid, quad_out} !== {1'b1, exp_q})
                    $display("FAIL wrap[%0d]: got v=%b q=%b expected v=1 q=%b", c, out_valid, quad_out, exp_q);
                else passed++;
            end
        end
        in_valid = 1'b0; core_valid = 1'b0;
        tick();
        checks++;
        if ({in_ready, unf_err} !== 2'b10) $display("FAIL wrap_end: got rdy/unf=%b expected 10", {in_ready, unf_err});
        else passed++;
    endtask

    task automatic test_underflow();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        core_valid = 1'b1; core_angle = 16'hC123;
        tick();
        core_valid = 1'b0;
        checks++;
        if ({out_valid, angle_out, quad_out, unf_err} !== {1'b1, 16'hC123, 2'b00, 1'b1})
            $display("FAIL underflow: got v=%b a=%h q=%b unf=%b expected v=1 a=c123 q=00 unf=1", out_valid, angle_out, quad_out, unf_err);
        else passed++;
        // Push and pop together on an empty FIFO: the push must survive.
        in_valid = 1'b1; drive_code(2'b01); core_valid = 1'b1; core_angle = 16'h2000;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({angle_out, quad_out} !== {16'h2000, 2'b00})
            $display("FAIL empty_pushpop: got a=%h q=%b expected a=2000 q=00", angle_out, quad_out);
        else passed++;
        tick();
        core_valid = 1'b0;
        checks++;
        if ({angle_out, quad_out} !== {16'hA000, 2'b01})
            $display("FAIL empty_kept: got a=%h q=%b expected a=a000 q=01", angle_out, quad_out);
        else passed++;
    endtask

    task automatic test_reset_inflight();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; drive_code(2'b11);
            tick();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({unf_err, ovf_err, in_ready, pre_valid, out_valid, pre_x} !== {5'b00100, 16'h0})
            $display("FAIL mid_reset: got unf=%b ovf=%b rdy=%b pv=%b ov=%b px=%h", unf_err, ovf_err, in_ready, pre_valid, out_valid, pre_x);
        else passed++;
        core_valid = 1'b1; core_angle = 16'hA000;
        tick();
        core_valid = 1'b0;
        checks++;
        if ({out_valid, angle_out, quad_out, unf_err} !== {1'b1, 16'hA000, 2'b00, 1'b1})
            $display("FAIL post_reset_unf: got v=%b a=%h q=%b unf=%b expected v=1 a=a000 q=00 unf=1", out_valid, angle_out, quad_out, unf_err);
        else passed++;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; x_in = '0; y_in = '0;
        core_valid = 1'b0; core_mag = '0; core_angle = '0; core_micro_rot = '0;
        test_reset();
        test_quadrants();
        test_fifo_full();
        test_wrap();
        test_underflow();
        test_reset_inflight();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
